tiled_control_unit: RTL

Parametrised successor to the TPU top-level controller. It sequences a full tiled matrix multiply, C[M×N] (+)= A[M×K]·W[K×N], on a MUL_SIZE×MUL_SIZE systolic array, iterating weight tiles over N and K. It drives unified-buffer activation reads, MAC enables and accumulator write/add/mask, and exchanges a valid/ready handshake with the weight FIFO path. Backpressure stall and an accumulate-onto-existing mode are supported.

---
 rtl/tiled_control_unit_pkg.sv | 30 +++
 rtl/tiled_control_unit_if.sv | 38 +++
 rtl/tiled_control_unit_acc_write_pipe.sv | 61 ++++++
 rtl/tiled_control_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tiled_control_unit_pkg.sv
// ============================================================================
// tpu_package : shared types for the tiled matrix-multiply controller
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package tpu_package;

    localparam int DEFAULT_MUL_SIZE = 32;
    // Entry fields are sized for the largest supported array / accumulator
    localparam int ENTRY_ROW_W      = 16;
    localparam int ENTRY_MASK_W     = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT_W = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } ctrl_state_t;

    typedef struct packed {
        logic [ENTRY_ROW_W-1:0]  row;
        logic                    add;
        logic [ENTRY_MASK_W-1:0] mask;
    } acc_entry_t;

endpackage

`default_nettype wire

// File: rtl/tiled_control_unit_if.sv
// ============================================================================
// tiled_control_unit_if : weight handshake, activation read and accumulator bus
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface tiled_control_unit_if #(
    parameter int MUL_SIZE   = 32,
    parameter int UB_ADDR_W  = 12,
    parameter int ACC_ADDR_W = 7
);
    logic                  weight_tile_valid_i;
    logic                  weight_tile_ready_o;
    logic                  next_weight_tile_o;
    logic [UB_ADDR_W-1:0]  ub_addr_rd_o;
    logic                  load_activations_o;
    logic                  mac_compute_o;
    logic                  acc_wr_o;
    logic                  acc_add_o;
    logic [ACC_ADDR_W-1:0] acc_addr_wr_o;
    logic [MUL_SIZE-1:0]   acc_mask_o;

    modport master (
        input  weight_tile_valid_i,
        output weight_tile_ready_o, next_weight_tile_o, ub_addr_rd_o,
               load_activations_o, mac_compute_o, acc_wr_o, acc_add_o,
               acc_addr_wr_o, acc_mask_o
    );

    modport slave (
        output weight_tile_valid_i,
        input  weight_tile_ready_o, next_weight_tile_o, ub_addr_rd_o,
               load_activations_o, mac_compute_o, acc_wr_o, acc_add_o,
               acc_addr_wr_o, acc_mask_o
    );
endinterface

`default_nettype wire

// File: rtl/tiled_control_unit_acc_write_pipe.sv
// ============================================================================
// acc_write_pipe : stallable delay line carrying accumulator write commands
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_write_pipe
    import tpu_package::*;
#(
    parameter int PIPE_LAT   = 8,
    parameter int MUL_SIZE   = DEFAULT_MUL_SIZE,
    parameter int ACC_ADDR_W = 7
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_i,
    input  wire logic                  stall_i,
    input  wire logic                  push_i,
    input  wire acc_entry_t            entry_i,
    output logic                       acc_wr_o,
    output logic                       acc_add_o,
    output logic [ACC_ADDR_W-1:0]      acc_addr_wr_o,
    output logic [MUL_SIZE-1:0]        acc_mask_o,
    output logic                       empty_o
);

    acc_entry_t            stage_q [PIPE_LAT];
    logic [PIPE_LAT-1:0]   valid_q;
    logic                  w_pending;
    acc_entry_t            w_unused_out;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < PIPE_LAT; i++) stage_q[i] <= '0;
            valid_q <= '0;
        end else if (!stall_i) begin
            stage_q[0] <= push_i ? entry_i : '0;
            valid_q[0] <= push_i;
            for (int i = 1; i < PIPE_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Empty means nothing is queued behind the output stage, so the
    // entry now at the output is the last one still to be written.
    always_comb begin
        w_pending = 1'b0;
        for (int i = 0; i < PIPE_LAT - 1; i++) w_pending = w_pending | valid_q[i];
    end

    assign w_unused_out  = stage_q[PIPE_LAT-1];
    assign empty_o       = !w_pending;
    assign acc_wr_o      = valid_q[PIPE_LAT-1] && !stall_i;
    assign acc_add_o     = stage_q[PIPE_LAT-1].add;
    assign acc_addr_wr_o = stage_q[PIPE_LAT-1].row[ACC_ADDR_W-1:0];
    assign acc_mask_o    = stage_q[PIPE_LAT-1].mask[MUL_SIZE-1:0];

endmodule

`default_nettype wire

// File: rtl/tiled_control_unit.sv
// ============================================================================
// tiled_control_unit : sequences a tiled C (+)= A*W on a systolic array
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tiled_control_unit
    import tpu_package::*;
#(
    parameter int MUL_SIZE  = DEFAULT_MUL_SIZE,
    parameter int DIM_W     = 9,
    parameter int UB_ADDR_W = 12,
    parameter int ACC_DEPTH = 128,
    parameter int PIPE_LAT  = 2 * MUL_SIZE
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_i,
    input  wire logic                 start_i,
    input  wire logic [DIM_W-1:0]     M_DIM_i,
    input  wire logic [DIM_W-1:0]     K_DIM_i,
    input  wire logic [DIM_W-1:0]     N_DIM_i,
    input  wire logic [UB_ADDR_W-1:0] ub_base_i,
    input  wire logic                 accumulate_i,
    input  wire logic                 stall_i,
    tiled_control_unit_if.master      bus,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);

    localparam int ACC_ADDR_W = $clog2(ACC_DEPTH);

    ctrl_state_t            state_q, state_d;
    logic [ACC_ADDR_W-1:0]  m_last_q, row_q;
    logic [DIM_W-1:0]       tk_last_q, tn_last_q, kt_q, nt_q;
    logic [UB_ADDR_W-1:0]   base_q, rd_ptr_q;
    logic                   acc_mode_q;
    logic [MUL_SIZE-1:0]    last_mask_q;

    logic                   w_bad, w_row_end, w_kt_end, w_nt_end, w_empty;
    logic [DIM_W-1:0]       w_tk_last, w_tn_last;
    logic [MUL_SIZE-1:0]    w_last_mask;
    int                     w_rem;
    logic                   w_ready, w_load, w_mac, w_nwt, w_done, w_err, w_push;
    acc_entry_t             w_entry;

    always_comb begin
        w_bad = (M_DIM_i == '0) || (K_DIM_i == '0) || (N_DIM_i == '0) ||
                (int'(M_DIM_i) > ACC_DEPTH);
        w_tk_last = DIM_W'((int'(K_DIM_i) + MUL_SIZE - 1) / MUL_SIZE - 1);
        w_tn_last = DIM_W'((int'(N_DIM_i) + MUL_SIZE - 1) / MUL_SIZE - 1);
        w_rem     = int'(N_DIM_i) % MUL_SIZE;
        for (int i = 0; i < MUL_SIZE; i++) w_last_mask[i] = (w_rem == 0) || (i < w_rem);
    end

    assign w_row_end = (row_q == m_last_q);
    assign w_kt_end  = (kt_q == tk_last_q);
    assign w_nt_end  = (nt_q == tn_last_q);

    always_comb begin
        state_d = state_q;
        w_ready = 1'b0;
        w_load  = 1'b0;
        w_mac   = 1'b0;
        w_nwt   = 1'b0;
        w_done  = 1'b0;
        w_err   = 1'b0;
        w_push  = 1'b0;
        w_entry = '0;
        w_entry.row[ACC_ADDR_W-1:0] = row_q;
        w_entry.add                 = (kt_q != '0) || acc_mode_q;
        w_entry.mask[MUL_SIZE-1:0]  = w_nt_end ? last_mask_q : '1;
        case (state_q)
            ST_IDLE: if (start_i) begin
                if (w_bad) w_err = 1'b1;
                else       state_d = ST_WAIT_W;
            end
            ST_WAIT_W: begin
                w_ready = 1'b1;
                if (bus.weight_tile_valid_i) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                w_load = 1'b1;
                w_mac  = 1'b1;
                w_push = 1'b1;
                if (w_row_end) begin
                    w_nwt   = 1'b1;
                    state_d = (w_kt_end && w_nt_end) ? ST_DRAIN : ST_WAIT_W;
                end
            end
            ST_DRAIN: begin
                w_mac = 1'b1;
                if (w_empty) state_d = ST_DONE;
            end
            ST_DONE: begin
                w_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Backpressure freezes the whole block and suppresses every strobe
        if (stall_i) begin
            state_d = state_q;
            w_ready = 1'b0;
            w_load  = 1'b0;
            w_mac   = 1'b0;
            w_nwt   = 1'b0;
            w_done  = 1'b0;
            w_err   = 1'b0;
            w_push  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            m_last_q    <= '0;
            row_q       <= '0;
            tk_last_q   <= '0;
            tn_last_q   <= '0;
            kt_q        <= '0;
            nt_q        <= '0;
            base_q      <= '0;
            rd_ptr_q    <= '0;
            acc_mode_q  <= 1'b0;
            last_mask_q <= '0;
        end else begin
            state_q <= state_d;
            if (!stall_i) begin
                if (state_q == ST_IDLE && start_i && !w_bad) begin
                    m_last_q    <= ACC_ADDR_W'(M_DIM_i - 1'b1);
                    tk_last_q   <= w_tk_last;
                    tn_last_q   <= w_tn_last;
                    acc_mode_q  <= accumulate_i;
                    last_mask_q <= w_last_mask;
                    base_q      <= ub_base_i;
                    rd_ptr_q    <= ub_base_i;
                    row_q       <= '0;
                    kt_q        <= '0;
                    nt_q        <= '0;
                end else if (state_q == ST_STREAM) begin
                    // Consecutive K tiles are contiguous in the buffer; a new
                    // N tile restarts the activation walk from the base.
                    if (!w_row_end) begin
                        row_q    <= row_q + 1'b1;
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                    end else if (!w_kt_end) begin
                        row_q    <= '0;
                        kt_q     <= kt_q + 1'b1;
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                    end else begin
                        row_q    <= '0;
                        kt_q     <= '0;
                        nt_q     <= nt_q + 1'b1;
                        rd_ptr_q <= base_q;
                    end
                end
            end
        end
    end

    acc_write_pipe #(
        .PIPE_LAT   (PIPE_LAT),
        .MUL_SIZE   (MUL_SIZE),
        .ACC_ADDR_W (ACC_ADDR_W)
    ) u_acc_write_pipe (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .push_i        (w_push),
        .entry_i       (w_entry),
        .acc_wr_o      (bus.acc_wr_o),
        .acc_add_o     (bus.acc_add_o),
        .acc_addr_wr_o (bus.acc_addr_wr_o),
        .acc_mask_o    (bus.acc_mask_o),
        .empty_o       (w_empty)
    );

    assign bus.weight_tile_ready_o = w_ready;
    assign bus.next_weight_tile_o  = w_nwt;
    assign bus.ub_addr_rd_o        = rd_ptr_q;
    assign bus.load_activations_o  = w_load;
    assign bus.mac_compute_o       = w_mac;
    assign busy_o                  = (state_q != ST_IDLE);
    assign done_o                  = w_done;
    assign err_o                   = w_err;

endmodule

`default_nettype wire
